// File: rtl/uart_program_loader.sv
// UART program loader: receives a framed, XOR-checked image over 8N1 serial
// and writes it into byte-wide instruction memory while holding the CPU in reset.
module uart_program_loader #(
    parameter int CLK_HZ    = 100000000,
    parameter int BAUD      = 115200,
    parameter int MEM_BYTES = 72,
    parameter int ADDR_W    = 7
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB) + 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {L_SYNC, L_LEN, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_e;

    // rx_s3_q is the previous synced sample, used only for falling-edge detect
    logic rx_s1_q, rx_s2_q, rx_s3_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid, frame_err;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    cnt_d      = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    byte_valid = rx_s2_q;
                    frame_err  = !rx_s2_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    ld_state_e         state_q, state_d;
    logic [9:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [9:0]        len_w;
    logic              is_sync;

    assign len_w   = {shift_q, 2'b00};
    assign is_sync = byte_valid && (shift_q == 8'hA5);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= L_SYNC;
            len_q   <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            csum_q  <= csum_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        // address advances the cycle after each write strobe
        if (we_q) addr_d = addr_q + ADDR_W'(1);
        case (state_q)
            L_SYNC: if (is_sync) state_d = L_LEN;
            L_LEN: begin
                if (frame_err) begin
                    state_d = L_ERR;
                end else if (byte_valid) begin
                    if (shift_q == 8'h00 || len_w > 10'(MEM_BYTES)) begin
                        state_d = L_ERR;
                    end else begin
                        len_d   = len_w;
                        addr_d  = '0;
                        csum_d  = '0;
                        state_d = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (frame_err) begin
                    state_d = L_ERR;
                end else if (byte_valid) begin
                    we_d    = 1'b1;
                    wdata_d = shift_q;
                    csum_d  = csum_q ^ shift_q;
                    if (10'(addr_q) + 10'd1 == len_q) state_d = L_CSUM;
                end
            end
            L_CSUM: begin
                if (frame_err) state_d = L_ERR;
                else if (byte_valid) state_d = (shift_q == csum_q) ? L_DONE : L_ERR;
            end
            L_DONE, L_ERR: if (is_sync) state_d = L_LEN;
            default: state_d = L_SYNC;
        endcase
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = (state_q != L_DONE);
    assign load_done  = (state_q == L_DONE);
    assign load_error = (state_q == L_ERR);

endmodule
